// File: rtl/pix_fill_ctrl.sv
// Input-pixel fill controller: accepts bus pixels into a circular input pad and
// tracks resident / released pixels for the downstream datapath controller.
module pix_fill_ctrl #(
    parameter int PIX_WD = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH),
    parameter int LEN_WD = 8
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    input  logic [LEN_WD-1:0] i_len,
    input  logic              i_pix_valid,
    output logic              o_pix_ready,
    input  logic [PIX_WD-1:0] i_pix_data,
    output logic              o_wr_en,
    output logic [AW-1:0]     o_wr_addr,
    output logic [PIX_WD-1:0] o_wr_data,
    output logic [AW-1:0]     o_base_addr,
    output logic [AW:0]       o_avail,
    input  logic              i_rel_valid,
    input  logic [AW:0]       i_rel_cnt,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t            state;
    logic [LEN_WD-1:0] len;
    logic [LEN_WD-1:0] rcv_cnt;
    logic [AW:0]       occ;
    logic [AW-1:0]     wr_ptr;

    logic              hs;
    logic              rel_active;
    logic              rel_ok;
    logic              rel_bad;
    logic [AW:0]       rel_amt;
    logic [AW:0]       avail_next;
    logic [AW:0]       occ_next;

    // Ready depends only on registered state, so there is no path from i_pix_valid.
    assign o_pix_ready = (state == FILL) && (rcv_cnt < len) && (occ < FULL);
    assign hs          = i_pix_valid && o_pix_ready;

    assign rel_active  = i_rel_valid && ((state == FILL) || (state == DRAIN));
    assign rel_ok      = rel_active && (i_rel_cnt <= o_avail);
    assign rel_bad     = rel_active && !rel_ok;
    assign rel_amt     = rel_ok ? i_rel_cnt : '0;

    // o_wr_en is the commit of last cycle's handshake; occ already counted it.
    assign avail_next  = o_avail + {{AW{1'b0}}, o_wr_en} - rel_amt;
    assign occ_next    = occ + {{AW{1'b0}}, hs} - rel_amt;

    // NOTE: all state below is updated with non-blocking assignments only, so every
    // right-hand side sees the pre-edge value regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= IDLE;
            len         <= '0;
            rcv_cnt     <= '0;
            occ         <= '0;
            wr_ptr      <= '0;
            o_wr_en     <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            o_base_addr <= '0;
            o_avail     <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            o_wr_en <= hs;
            o_done  <= 1'b0;
            if (hs) begin
                o_wr_addr <= wr_ptr;
                o_wr_data <= i_pix_data;
                wr_ptr    <= wr_ptr + AW'(1);
                rcv_cnt   <= rcv_cnt + LEN_WD'(1);
            end

            if ((state == FILL) || (state == DRAIN)) begin
                occ     <= occ_next;
                o_avail <= avail_next;
                if (rel_ok)
                    o_base_addr <= o_base_addr + rel_amt[AW-1:0];
                if (rel_bad)
                    o_error <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (i_start) begin
                        state       <= FILL;
                        len         <= i_len;
                        rcv_cnt     <= '0;
                        occ         <= '0;
                        wr_ptr      <= '0;
                        o_avail     <= '0;
                        o_base_addr <= '0;
                        o_error     <= 1'b0;
                        o_busy      <= 1'b1;
                    end
                end
                FILL: begin
                    if (rcv_cnt == len)
                        state <= DRAIN;
                end
                DRAIN: begin
                    // Finishing on the post-release count lets the last release end the tile.
                    if (!o_wr_en && (avail_next == '0)) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pix_fill_ctrl.sv
// Directed bench for pix_fill_ctrl: pad writes go through a scoreboard queue,
// status outputs are checked at hand-computed cycles.
module tb_pix_fill_ctrl;

    localparam int PIX_WD = 8;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int LEN_WD = 8;

    logic              clk;
    logic              rst_n;
    logic              i_start;
    logic [LEN_WD-1:0] i_len;
    logic              i_pix_valid;
    logic              o_pix_ready;
    logic [PIX_WD-1:0] i_pix_data;
    logic              o_wr_en;
    logic [AW-1:0]     o_wr_addr;
    logic [PIX_WD-1:0] o_wr_data;
    logic [AW-1:0]     o_base_addr;
    logic [AW:0]       o_avail;
    logic              i_rel_valid;
    logic [AW:0]       i_rel_cnt;
    logic              o_busy;
    logic              o_done;
    logic              o_error;

    int n_checks = 0;
    int n_errors = 0;

    logic [AW+PIX_WD-1:0] exp_q[$];

    pix_fill_ctrl #(
        .PIX_WD(PIX_WD), .DEPTH(DEPTH), .AW(AW), .LEN_WD(LEN_WD)
    ) dut (
        .i_clk       (clk),
        .i_rstn      (rst_n),
        .i_start     (i_start),
        .i_len       (i_len),
        .i_pix_valid (i_pix_valid),
        .o_pix_ready (o_pix_ready),
        .i_pix_data  (i_pix_data),
        .o_wr_en     (o_wr_en),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .o_base_addr (o_base_addr),
        .o_avail     (o_avail),
        .i_rel_valid (i_rel_valid),
        .i_rel_cnt   (i_rel_cnt),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_error     (o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_tile(input logic [LEN_WD-1:0] len);
        i_start = 1'b1;
        i_len   = len;
        tick();
        i_start = 1'b0;
    endtask

    task automatic push_wr(input int addr, input logic [PIX_WD-1:0] data);
        logic [AW-1:0] a;
        a = AW'(addr);
        exp_q.push_back({a, data});
    endtask

    task automatic check_reset_values();
        check("rst_ready", o_pix_ready, 0);
        check("rst_wr_en", o_wr_en, 0);
        check("rst_wr_addr", o_wr_addr, 0);
        check("rst_wr_data", o_wr_data, 0);
        check("rst_base", o_base_addr, 0);
        check("rst_avail", o_avail, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_error", o_error, 0);
    endtask

    // Pad-write monitor: every committed write must match the next expected beat.
    always @(negedge clk) begin
        if (o_wr_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL wr_unexpected: got addr=%0d data=0x%0h, expected no write at %0t",
                         o_wr_addr, o_wr_data, $time);
            end else begin
                check("wr_beat", {20'd0, o_wr_addr, o_wr_data}, {20'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        i_start     = 1'b0;
        i_len       = '0;
        i_pix_valid = 1'b0;
        i_pix_data  = '0;
        i_rel_valid = 1'b0;
        i_rel_cnt   = '0;
        tick();
        tick();
        check_reset_values();
        rst_n = 1'b1;
        tick();

        // Basic fill: 5 pixels, then release all
        i_pix_valid = 1'b1;
        start_tile(8'd5);
        for (int k = 0; k < 5; k++) begin
            check("fill_ready", o_pix_ready, 1);
            check("fill_avail", o_avail, (k >= 2) ? k - 1 : 0);
            i_pix_data = 8'hA0 + 8'(k);
            push_wr(k, 8'hA0 + 8'(k));
            tick();
        end
        check("fill_ready_end", o_pix_ready, 0);
        check("fill_avail_4", o_avail, 4);
        i_pix_valid = 1'b0;
        tick();
        check("fill_avail_5", o_avail, 5);
        check("fill_busy", o_busy, 1);
        check("fill_no_done", o_done, 0);
        i_rel_valid = 1'b1;
        i_rel_cnt   = 5'd5;
        tick();
        i_rel_valid = 1'b0;
        check("fill_done", o_done, 1);
        check("fill_avail_0", o_avail, 0);
        check("fill_base", o_base_addr, 5);
        tick();
        check("fill_done_pulse", o_done, 0);
        check("fill_busy_low", o_busy, 0);

        // Full buffer and backpressure: 20 pixels, 16-entry pad
        i_pix_valid = 1'b1;
        start_tile(8'd20);
        for (int k = 0; k < 16; k++) begin
            check("full_ready", o_pix_ready, 1);
            i_pix_data = 8'hB0 + 8'(k);
            push_wr(k, 8'hB0 + 8'(k));
            tick();
        end
        check("full_ready_low", o_pix_ready, 0);
        tick();
        check("full_ready_still_low", o_pix_ready, 0);
        check("full_avail_16", o_avail, 16);
        i_rel_valid = 1'b1;
        i_rel_cnt   = 5'd4;
        tick();
        i_rel_valid = 1'b0;
        check("full_ready_after_rel", o_pix_ready, 1);
        check("full_base_4", o_base_addr, 4);
        check("full_avail_12", o_avail, 12);
        for (int k = 0; k < 4; k++) begin
            check("wrap_ready", o_pix_ready, 1);
            i_pix_data = 8'hC0 + 8'(k);
            push_wr(k, 8'hC0 + 8'(k));
            tick();
        end
        check("wrap_ready_end", o_pix_ready, 0);
        i_pix_valid = 1'b0;
        tick();
        check("wrap_avail_16", o_avail, 16);
        i_rel_valid = 1'b1;
        i_rel_cnt   = 5'd16;
        tick();
        i_rel_valid = 1'b0;
        check("wrap_done", o_done, 1);
        check("wrap_base", o_base_addr, 4);
        tick();
        check("wrap_busy_low", o_busy, 0);

        // Simultaneous commit/release, then over-release
        i_pix_valid = 1'b1;
        start_tile(8'd4);
        for (int k = 0; k < 4; k++) begin
            i_pix_data = 8'hD0 + 8'(k);
            push_wr(k, 8'hD0 + 8'(k));
            tick();
        end
        check("simul_avail_3", o_avail, 3);
        check("simul_commit", o_wr_en, 1);
        i_pix_valid = 1'b0;
        i_rel_valid = 1'b1;
        i_rel_cnt   = 5'd2;
        tick();
        check("simul_avail_2", o_avail, 2);
        check("simul_base_2", o_base_addr, 2);
        i_rel_cnt = 5'd3;
        tick();
        check("over_error", o_error, 1);
        check("over_avail", o_avail, 2);
        check("over_base", o_base_addr, 2);
        check("over_busy", o_busy, 1);
        i_rel_cnt = 5'd2;
        tick();
        i_rel_valid = 1'b0;
        check("over_done", o_done, 1);
        check("over_error_sticky", o_error, 1);
        tick();
        check("over_busy_low", o_busy, 0);

        // Zero length tile; start also clears the sticky error
        i_pix_valid = 1'b1;
        start_tile(8'd0);
        check("zero_error_clr", o_error, 0);
        check("zero_busy", o_busy, 1);
        check("zero_ready_s1", o_pix_ready, 0);
        tick();
        check("zero_ready_s2", o_pix_ready, 0);
        check("zero_no_done_s2", o_done, 0);
        tick();
        check("zero_done_s3", o_done, 1);
        tick();
        check("zero_busy_low", o_busy, 0);
        i_pix_valid = 1'b0;

        // Start pulsed during FILL must not change the tile length
        start_tile(8'd3);
        check("ign_ready", o_pix_ready, 1);
        tick();
        i_start = 1'b1;
        i_len   = 8'd9;
        tick();
        i_start     = 1'b0;
        i_pix_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("ign_fill_ready", o_pix_ready, 1);
            i_pix_data = 8'hE0 + 8'(k);
            push_wr(k, 8'hE0 + 8'(k));
            tick();
        end
        check("ign_len_kept", o_pix_ready, 0);
        i_pix_valid = 1'b0;
        tick();
        check("ign_avail_3", o_avail, 3);
        i_rel_valid = 1'b1;
        i_rel_cnt   = 5'd3;
        tick();
        i_rel_valid = 1'b0;
        check("ign_done", o_done, 1);
        tick();

        // Reset mid-tile after 7 accepts; 7th commit is dropped
        i_pix_valid = 1'b1;
        start_tile(8'd10);
        for (int k = 0; k < 7; k++) begin
            check("mid_ready", o_pix_ready, 1);
            i_pix_data = 8'hF0 + 8'(k);
            if (k < 6) push_wr(k, 8'hF0 + 8'(k));
            tick();
        end
        rst_n       = 1'b0;
        i_pix_valid = 1'b0;
        #1;
        check_reset_values();
        tick();
        rst_n = 1'b1;
        tick();
        i_pix_valid = 1'b1;
        start_tile(8'd2);
        for (int k = 0; k < 2; k++) begin
            i_pix_data = 8'h55 + 8'(k);
            push_wr(k, 8'h55 + 8'(k));
            tick();
        end
        i_pix_valid = 1'b0;
        tick();
        check("post_rst_avail", o_avail, 2);
        i_rel_valid = 1'b1;
        i_rel_cnt   = 5'd2;
        tick();
        i_rel_valid = 1'b0;
        check("post_rst_done", o_done, 1);
        tick();
        tick();
        check("sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
